// File: rtl/alu_step_sequencer.sv
// Hardwired T0-T5 control-step generator for register-to-register ALU instructions
// on the single-bus datapath: fetch, memory wait, decode, execute, write-back.
module alu_step_sequencer #(
    parameter int  DATA_WIDTH = 32,
    parameter int  REG_SEL_W  = 4,
    localparam int NUM_REGS   = 2 ** REG_SEL_W
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Start,
    input  logic                  Stall,
    input  logic                  Mem_Ready,
    input  logic [DATA_WIDTH-1:0] IR_Data,
    output logic                  PC_Out,
    output logic                  MAR_In,
    output logic                  IncPC,
    output logic                  Z_In,
    output logic                  ZLO_Out,
    output logic                  PC_In,
    output logic                  Read,
    output logic                  MDR_In,
    output logic                  MDR_Out,
    output logic                  IR_In,
    output logic                  Y_In,
    output logic [NUM_REGS-1:0]   R_Out,
    output logic [NUM_REGS-1:0]   R_In,
    output logic [4:0]            CONTROL,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Illegal,
    output logic [2:0]            Step
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T1W  = 3'd3;
    localparam logic [2:0] S_T2   = 3'd4;
    localparam logic [2:0] S_T3   = 3'd5;
    localparam logic [2:0] S_T4   = 3'd6;
    localparam logic [2:0] S_T5   = 3'd7;

    localparam int OP_LSB = DATA_WIDTH - 5;
    localparam int RA_LSB = OP_LSB - REG_SEL_W;
    localparam int RB_LSB = RA_LSB - REG_SEL_W;
    localparam int RC_LSB = RB_LSB - REG_SEL_W;

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [4:0]           op_q;
    logic [REG_SEL_W-1:0] ra_q;
    logic [REG_SEL_W-1:0] rb_q;
    logic [REG_SEL_W-1:0] rc_q;

    logic [4:0]           ir_op;
    logic [REG_SEL_W-1:0] ir_ra;
    logic [REG_SEL_W-1:0] ir_rb;
    logic [REG_SEL_W-1:0] ir_rc;
    logic                 ir_legal;

    function automatic logic is_binary(input logic [4:0] op);
        is_binary = (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        is_unary = (op == 5'd16) || (op == 5'd17);
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign ir_op    = IR_Data[OP_LSB +: 5];
    assign ir_ra    = IR_Data[RA_LSB +: REG_SEL_W];
    assign ir_rb    = IR_Data[RB_LSB +: REG_SEL_W];
    assign ir_rc    = IR_Data[RC_LSB +: REG_SEL_W];
    assign ir_legal = is_binary(ir_op) || is_unary(ir_op);

    // Bits below Rc carry immediates for other instruction formats.
    generate
        if (RC_LSB > 0) begin : g_low_bits
            logic unused_ir_low;
            assign unused_ir_low = ^IR_Data[RC_LSB-1:0];
        end
    endgenerate

    always_comb begin
        next_state = state;
        if (!Stall) begin
            case (state)
                S_IDLE:  if (Start) next_state = S_T0;
                S_T0:    next_state = S_T1;
                S_T1:    next_state = Mem_Ready ? S_T2 : S_T1W;
                S_T1W:   if (Mem_Ready) next_state = S_T2;
                S_T2:    next_state = S_T3;
                S_T3:    next_state = ir_legal ? S_T4 : S_IDLE;
                S_T4:    next_state = S_T5;
                S_T5:    next_state = Start ? S_T0 : S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator runs the blocks.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: the captured fields are reset too, so T4/T5 decode never sees X
    // and a cleared sequencer presents a known, all-zero view.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (state == S_T3 && !Stall) begin
            op_q <= ir_op;
            ra_q <= ir_ra;
            rb_q <= ir_rb;
            rc_q <= ir_rc;
        end
    end

    assign Busy = (state != S_IDLE);
    assign Step = state;

    // NOTE: every output gets a default before the case, so no path leaves a
    // strobe unassigned and no latch is inferred.
    always_comb begin
        PC_Out  = 1'b0;
        MAR_In  = 1'b0;
        IncPC   = 1'b0;
        Z_In    = 1'b0;
        ZLO_Out = 1'b0;
        PC_In   = 1'b0;
        Read    = 1'b0;
        MDR_In  = 1'b0;
        MDR_Out = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        R_Out   = '0;
        R_In    = '0;
        CONTROL = '0;
        Done    = 1'b0;
        Illegal = 1'b0;
        if (!Stall) begin
            case (state)
                S_T0: begin
                    PC_Out = 1'b1;
                    MAR_In = 1'b1;
                    IncPC  = 1'b1;
                    Z_In   = 1'b1;
                end
                S_T1: begin
                    ZLO_Out = 1'b1;
                    PC_In   = 1'b1;
                    Read    = 1'b1;
                    MDR_In  = 1'b1;
                end
                S_T1W: begin
                    Read   = 1'b1;
                    MDR_In = 1'b1;
                end
                S_T2: begin
                    MDR_Out = 1'b1;
                    IR_In   = 1'b1;
                end
                // Fields are not captured until this state ends, so decode the IR live.
                S_T3: begin
                    if (ir_legal) begin
                        R_Out = onehot(ir_rb);
                        Y_In  = 1'b1;
                    end else begin
                        Illegal = 1'b1;
                    end
                end
                S_T4: begin
                    CONTROL = op_q;
                    Z_In    = 1'b1;
                    R_Out   = onehot(is_binary(op_q) ? rc_q : rb_q);
                end
                S_T5: begin
                    ZLO_Out = 1'b1;
                    R_In    = onehot(ra_q);
                    Done    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer: fetch/execute sequences, memory wait,
// illegal opcode, stall, back-to-back issue and asynchronous clear.
module tb_alu_step_sequencer;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        Start;
    logic        Stall;
    logic        Mem_Ready;
    logic [31:0] IR_Data;
    logic        PC_Out, MAR_In, IncPC, Z_In, ZLO_Out, PC_In, Read, MDR_In, MDR_Out, IR_In, Y_In;
    logic [15:0] R_Out;
    logic [15:0] R_In;
    logic [4:0]  CONTROL;
    logic        Busy, Done, Illegal;
    logic [2:0]  Step;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Strobe vector order: PC_Out MAR_In IncPC Z_In ZLO_Out PC_In Read MDR_In MDR_Out IR_In Y_In
    localparam logic [10:0] ST_NONE = 11'h000;
    localparam logic [10:0] ST_T0   = 11'h780;
    localparam logic [10:0] ST_T1   = 11'h078;
    localparam logic [10:0] ST_T1W  = 11'h018;
    localparam logic [10:0] ST_T2   = 11'h006;
    localparam logic [10:0] ST_T3   = 11'h001;
    localparam logic [10:0] ST_T4   = 11'h080;
    localparam logic [10:0] ST_T5   = 11'h040;
    // Flag vector order: Busy Done Illegal
    localparam logic [2:0]  F_IDLE  = 3'b000;
    localparam logic [2:0]  F_BUSY  = 3'b100;
    localparam logic [2:0]  F_DONE  = 3'b110;
    localparam logic [2:0]  F_ILL   = 3'b101;

    localparam logic [31:0] IR_ADD  = 32'h4A92_0000;
    localparam logic [31:0] IR_NEG  = 32'h8290_0000;

    alu_step_sequencer dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Start     (Start),
        .Stall     (Stall),
        .Mem_Ready (Mem_Ready),
        .IR_Data   (IR_Data),
        .PC_Out    (PC_Out),
        .MAR_In    (MAR_In),
        .IncPC     (IncPC),
        .Z_In      (Z_In),
        .ZLO_Out   (ZLO_Out),
        .PC_In     (PC_In),
        .Read      (Read),
        .MDR_In    (MDR_In),
        .MDR_Out   (MDR_Out),
        .IR_In     (IR_In),
        .Y_In      (Y_In),
        .R_Out     (R_Out),
        .R_In      (R_In),
        .CONTROL   (CONTROL),
        .Busy      (Busy),
        .Done      (Done),
        .Illegal   (Illegal),
        .Step      (Step)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [2:0] step, input logic [10:0] strobes,
                              input logic [15:0] r_out, input logic [15:0] r_in,
                              input logic [4:0] ctrl, input logic [2:0] flags);
        #1;
        check({tag, ".step"},    32'(Step), 32'(step));
        check({tag, ".strobes"}, 32'({PC_Out, MAR_In, IncPC, Z_In, ZLO_Out, PC_In, Read,
                                      MDR_In, MDR_Out, IR_In, Y_In}), 32'(strobes));
        check({tag, ".r_out"},   32'(R_Out), 32'(r_out));
        check({tag, ".r_in"},    32'(R_In), 32'(r_in));
        check({tag, ".control"}, 32'(CONTROL), 32'(ctrl));
        check({tag, ".flags"},   32'({Busy, Done, Illegal}), 32'(flags));
    endtask

    // Presents Start for one edge; returns inside the T0 cycle.
    task automatic issue(input logic [31:0] ir);
        IR_Data = ir;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
    endtask

    initial begin
        Clear     = 1'b0;
        Start     = 1'b0;
        Stall     = 1'b0;
        Mem_Ready = 1'b1;
        IR_Data   = '0;
        expect_cyc("reset", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);
        #10;
        Clear = 1'b1;
        tick();

        // Binary add: opcode 9, Ra=5, Rb=2, Rc=4
        issue(IR_ADD);
        expect_cyc("add.t0", 3'd1, ST_T0, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("add.t1", 3'd2, ST_T1, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("add.t2", 3'd4, ST_T2, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("add.t3", 3'd5, ST_T3, 16'h0004, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("add.t4", 3'd6, ST_T4, 16'h0010, 16'h0, 5'd9, F_BUSY);
        tick(); expect_cyc("add.t5", 3'd7, ST_T5, 16'h0, 16'h0020, 5'd0, F_DONE);
        tick(); expect_cyc("add.idle", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);

        // Unary neg; IR_Data is scrambled after T3 and must not disturb T4/T5
        issue(IR_NEG);
        tick(); tick(); tick();
        expect_cyc("neg.t3", 3'd5, ST_T3, 16'h0004, 16'h0, 5'd0, F_BUSY);
        tick();
        IR_Data = 32'h1FFF_FFFF;
        expect_cyc("neg.t4", 3'd6, ST_T4, 16'h0004, 16'h0, 5'd16, F_BUSY);
        tick(); expect_cyc("neg.t5", 3'd7, ST_T5, 16'h0, 16'h0020, 5'd0, F_DONE);
        tick(); expect_cyc("neg.idle", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);

        // Memory wait: Mem_Ready low during T1 and two T1W cycles
        issue(IR_ADD);
        Mem_Ready = 1'b0;
        tick(); expect_cyc("mw.t1", 3'd2, ST_T1, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("mw.w1", 3'd3, ST_T1W, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("mw.w2", 3'd3, ST_T1W, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick();
        Mem_Ready = 1'b1;
        expect_cyc("mw.w3", 3'd3, ST_T1W, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("mw.t2", 3'd4, ST_T2, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); tick(); tick();
        expect_cyc("mw.t5", 3'd7, ST_T5, 16'h0, 16'h0020, 5'd0, F_DONE);
        tick(); expect_cyc("mw.idle", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);

        // Illegal opcode 0
        issue(32'h0000_0000);
        tick(); tick(); tick();
        expect_cyc("ill.t3", 3'd5, ST_NONE, 16'h0, 16'h0, 5'd0, F_ILL);
        tick(); expect_cyc("ill.idle", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);

        // Start is ignored while stalled in IDLE
        Stall = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Stall = 1'b0;
        expect_cyc("stall.idle", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);

        // Stall for two cycles in T4, then back-to-back issue from T5
        issue(IR_ADD);
        tick(); tick(); tick(); tick();
        expect_cyc("st.t4", 3'd6, ST_T4, 16'h0010, 16'h0, 5'd9, F_BUSY);
        Stall = 1'b1;
        expect_cyc("st.hold1", 3'd6, ST_NONE, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); expect_cyc("st.hold2", 3'd6, ST_NONE, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick();
        Stall = 1'b0;
        expect_cyc("st.resume", 3'd6, ST_T4, 16'h0010, 16'h0, 5'd9, F_BUSY);
        tick();
        Start   = 1'b1;
        IR_Data = IR_NEG;
        expect_cyc("b2b.t5", 3'd7, ST_T5, 16'h0, 16'h0020, 5'd0, F_DONE);
        tick();
        Start = 1'b0;
        expect_cyc("b2b.t0", 3'd1, ST_T0, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); tick(); tick(); tick();
        expect_cyc("b2b.t4", 3'd6, ST_T4, 16'h0004, 16'h0, 5'd16, F_BUSY);
        tick(); tick();
        expect_cyc("b2b.idle", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);

        // Asynchronous clear in the middle of T4
        issue(IR_ADD);
        tick(); tick(); tick(); tick();
        expect_cyc("clr.t4", 3'd6, ST_T4, 16'h0010, 16'h0, 5'd9, F_BUSY);
        #1;
        Clear = 1'b0;
        expect_cyc("clr.async", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);
        tick();
        Clear = 1'b1;
        issue(IR_ADD);
        expect_cyc("clr.t0", 3'd1, ST_T0, 16'h0, 16'h0, 5'd0, F_BUSY);
        tick(); tick(); tick(); tick(); tick();
        expect_cyc("clr.t5", 3'd7, ST_T5, 16'h0, 16'h0020, 5'd0, F_DONE);
        tick(); expect_cyc("clr.idle", 3'd0, ST_NONE, 16'h0, 16'h0, 5'd0, F_IDLE);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
